// File: rtl/product_accumulator.sv
// product_accumulator: sums groups of up to LEN unsigned products.
// Emits one beat per group with sum, count and sticky overflow.
module product_accumulator #(
  parameter  int PROD_W = 16,
  parameter  int ACC_W  = 18,
  parameter  int LEN    = 8,
  localparam int CNT_W  = $clog2(LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [ACC_W-1:0]   r_out_sum;
  logic [CNT_W-1:0]   r_out_cnt;
  logic               r_out_ovf;

  logic               w_accept;
  logic               w_close;
  logic [ACC_W:0]     w_sum;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic               w_ovf_nx;

  // Accumulator is already cleared on close, so a beat taken in HOLD
  // adds into zero and starts the next group.
  assign w_sum    = {1'b0, r_acc}
                  + {{(ACC_W - PROD_W + 1){1'b0}}, in_prod};
  assign w_cnt_nx = r_cnt + CNT_W'(1);
  assign w_ovf_nx = r_ovf | w_sum[ACC_W];

  assign in_ready = (r_state == ACCUM) ? 1'b1 : out_ready;
  assign w_accept = in_valid & in_ready;
  assign w_close  = w_accept
                  & (in_last | (w_cnt_nx == CNT_W'(LEN)));

  assign out_valid = (r_state == HOLD);
  assign out_sum   = r_out_sum;
  assign out_count = r_out_cnt;
  assign out_ovf   = r_out_ovf;

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ACCUM: begin
        if (w_close) w_state_nx = HOLD;
      end
      HOLD: begin
        if (out_ready && !w_close) w_state_nx = ACCUM;
      end
      default: w_state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_close) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum[ACC_W-1:0];
      r_cnt <= w_cnt_nx;
      r_ovf <= w_ovf_nx;
    end
  end

  // Result registers only move on a close, which holds them
  // stable while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_sum <= '0;
      r_out_cnt <= '0;
      r_out_ovf <= 1'b0;
    end else if (w_close) begin
      r_out_sum <= w_sum[ACC_W-1:0];
      r_out_cnt <= w_cnt_nx;
      r_out_ovf <= w_ovf_nx;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed tests of the product accumulator.
// Inputs change and outputs are sampled on the falling edge.
module tb_product_accumulator;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 18;
  localparam int LEN    = 8;
  localparam int CNT_W  = $clog2(LEN + 1);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  int ntests = 0;
  int nfail  = 0;

  product_accumulator #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .LEN   (LEN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prod  (in_prod),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_ovf  (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input int p, input logic l);
    @(negedge clk);
    in_valid = v;
    in_prod  = PROD_W'(p);
    in_last  = l;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_prod = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    #1;
    ntests++;
    if (out_valid !== 1'b0 || out_sum !== '0 ||
        out_count !== '0 || out_ovf !== 1'b0) begin
      nfail++;
      $display("FAIL reset_outputs got v=%0b s=%0d c=%0d o=%0b exp 0 0 0 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ntests++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_in_ready got %0b exp 1", in_ready);
    end
  endtask

  task automatic test_full_group;
    int early;
    early = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3, 1'b0);
      if (out_valid !== 1'b0) early++;
    end
    ntests++;
    if (early != 0) begin
      nfail++;
      $display("FAIL full_early_valid got %0d exp 0", early);
    end
    drive(1'b0, 0, 1'b0);
    ntests++;
    if (out_valid !== 1'b1 || out_sum !== 18'd24 ||
        out_count !== 4'd8 || out_ovf !== 1'b0) begin
      nfail++;
      $display("FAIL full_result got v=%0b s=%0d c=%0d o=%0b exp 1 24 8 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    @(negedge clk);
    ntests++;
    if (out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL full_valid_pulse got %0b exp 0", out_valid);
    end
  endtask

  task automatic test_early_last;
    drive(1'b1, 100, 1'b0);
    drive(1'b1, 200, 1'b0);
    drive(1'b1, 300, 1'b1);
    drive(1'b0, 0, 1'b0);
    ntests++;
    if (out_valid !== 1'b1 || out_sum !== 18'd600 ||
        out_count !== 4'd3 || out_ovf !== 1'b0) begin
      nfail++;
      $display("FAIL last_result got v=%0b s=%0d c=%0d o=%0b exp 1 600 3 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    for (int i = 0; i < 8; i++) drive(1'b1, 1, 1'b0);
    drive(1'b0, 0, 1'b0);
    ntests++;
    if (out_valid !== 1'b1 || out_sum !== 18'd8 || out_count !== 4'd8) begin
      nfail++;
      $display("FAIL last_clear got v=%0b s=%0d c=%0d exp 1 8 8",
               out_valid, out_sum, out_count);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 8; i++) drive(1'b1, 'hFFFF, 1'b0);
    drive(1'b0, 0, 1'b0);
    ntests++;
    if (out_valid !== 1'b1 || out_sum !== 18'd262136 ||
        out_count !== 4'd8 || out_ovf !== 1'b1) begin
      nfail++;
      $display("FAIL ovf_result got v=%0b s=%0d c=%0d o=%0b exp 1 262136 8 1",
               out_valid, out_sum, out_count, out_ovf);
    end
    drive(1'b1, 1, 1'b0);
    drive(1'b1, 2, 1'b1);
    drive(1'b0, 0, 1'b0);
    ntests++;
    if (out_sum !== 18'd3 || out_count !== 4'd2 || out_ovf !== 1'b0) begin
      nfail++;
      $display("FAIL ovf_clear got s=%0d c=%0d o=%0b exp 3 2 0",
               out_sum, out_count, out_ovf);
    end
  endtask

  task automatic test_backpressure;
    int bad;
    drive(1'b1, 5, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_prod   = 16'd7;
    in_last   = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_sum !== 18'd5 || out_count !== 4'd1 ||
          out_ovf !== 1'b0) bad++;
      @(negedge clk);
    end
    ntests++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL bp_stall got %0d bad cycles exp 0", bad);
    end
    out_ready = 1'b1;
    #1;
    ntests++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL bp_passthru got %0b exp 1", in_ready);
    end
    drive(1'b0, 0, 1'b0);
    ntests++;
    if (out_valid !== 1'b1 || out_sum !== 18'd7 || out_count !== 4'd1) begin
      nfail++;
      $display("FAIL bp_release got v=%0b s=%0d c=%0d exp 1 7 1",
               out_valid, out_sum, out_count);
    end
    @(negedge clk);
    ntests++;
    if (out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL bp_drain got %0b exp 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i + 1, 1'b1);
      if (i > 0) begin
        ntests++;
        if (out_valid !== 1'b1 || out_sum !== ACC_W'(i) ||
            out_count !== 4'd1 || in_ready !== 1'b1) begin
          nfail++;
          $display("FAIL b2b_%0d got v=%0b s=%0d c=%0d r=%0b exp 1 %0d 1 1",
                   i, out_valid, out_sum, out_count, in_ready, i);
        end
      end
    end
    drive(1'b0, 0, 1'b0);
    ntests++;
    if (out_valid !== 1'b1 || out_sum !== 18'd4 || out_count !== 4'd1) begin
      nfail++;
      $display("FAIL b2b_4 got v=%0b s=%0d c=%0d exp 1 4 1",
               out_valid, out_sum, out_count);
    end
    @(negedge clk);
    ntests++;
    if (out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL b2b_end got %0b exp 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) drive(1'b1, 9, 1'b0);
    drive(1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    ntests++;
    if (out_valid !== 1'b0 || out_sum !== '0 ||
        out_count !== '0 || out_ovf !== 1'b0) begin
      nfail++;
      $display("FAIL rstmid_outputs got v=%0b s=%0d c=%0d o=%0b exp 0 0 0 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b1, 2, 1'b0);
    drive(1'b0, 0, 1'b0);
    ntests++;
    if (out_valid !== 1'b1 || out_sum !== 18'd16 ||
        out_count !== 4'd8 || out_ovf !== 1'b0) begin
      nfail++;
      $display("FAIL rstmid_result got v=%0b s=%0d c=%0d o=%0b exp 1 16 8 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_early_last();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
